// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one registered ALU among NUM_REQ requesters and tags responses.
// Optional macro ALU_ARB_LOCK_EN adds i_lock so one requester can hold the ALU across several ops.
module alu_arbiter #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned ID_BITS   = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*DATA_BITS-1:0] i_op_a,
    input  logic [NUM_REQ*DATA_BITS-1:0] i_op_b,
    input  logic [NUM_REQ-1:0]           i_op_sub,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           i_lock,
`endif
    output logic [NUM_REQ-1:0]           o_gnt,
    output logic [DATA_BITS-1:0]         o_alu_a,
    output logic [DATA_BITS-1:0]         o_alu_b,
    output logic                         o_alu_cin,
    input  logic [DATA_BITS-1:0]         i_alu_result,
    input  logic                         i_alu_cout,
    input  logic                         i_alu_zero,
    output logic                         o_rsp_valid,
    output logic [ID_BITS-1:0]           o_rsp_id,
    output logic [DATA_BITS-1:0]         o_rsp_result,
    output logic                         o_rsp_cout,
    output logic                         o_rsp_zero
);

    logic [ID_BITS-1:0] r_rr_ptr;
    logic               r_v_q;
    logic [ID_BITS-1:0] r_id_q;

    logic [ID_BITS-1:0] w_cand;
    logic [ID_BITS-1:0] w_win;
    logic               w_granted;
    logic [ID_BITS-1:0] w_ptr_nxt;

`ifdef ALU_ARB_LOCK_EN
    logic               r_lock_q;
    logic [ID_BITS-1:0] r_lock_id;
    logic               w_lock_q_nxt;
    logic [ID_BITS-1:0] w_lock_id_nxt;
`endif

    // Winner selection: first request at or after r_rr_ptr, wrapping; a held lock overrides.
    always_comb begin
        w_granted = 1'b0;
        w_win     = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_BITS'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_granted && i_req[w_cand]) begin
                w_granted = 1'b1;
                w_win     = w_cand;
            end
        end
`ifdef ALU_ARB_LOCK_EN
        if (r_lock_q) begin
            w_granted = i_req[r_lock_id];
            w_win     = r_lock_id;
        end
`endif
    end

    // One-hot grant and operand mux onto the ALU inputs.
    always_comb begin
        o_gnt     = '0;
        o_alu_a   = '0;
        o_alu_b   = '0;
        o_alu_cin = 1'b0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_granted && (w_win == ID_BITS'(j))) begin
                o_gnt[j]  = 1'b1;
                o_alu_a   = i_op_a[j*DATA_BITS +: DATA_BITS];
                o_alu_b   = i_op_b[j*DATA_BITS +: DATA_BITS];
                o_alu_cin = i_op_sub[j];
            end
        end
    end

    // Pointer rotation; a grant that takes or keeps the lock freezes the pointer.
    always_comb begin
        w_ptr_nxt = r_rr_ptr;
        if (w_granted) begin
            w_ptr_nxt = (32'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;
        end
`ifdef ALU_ARB_LOCK_EN
        w_lock_q_nxt  = r_lock_q;
        w_lock_id_nxt = r_lock_id;
        if (w_granted) begin
            if (i_lock[w_win]) begin
                w_lock_q_nxt  = 1'b1;
                w_lock_id_nxt = w_win;
                w_ptr_nxt     = r_rr_ptr;
            end else begin
                w_lock_q_nxt  = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rr_ptr  <= '0;
            r_v_q     <= 1'b0;
            r_id_q    <= '0;
`ifdef ALU_ARB_LOCK_EN
            r_lock_q  <= 1'b0;
            r_lock_id <= '0;
`endif
        end else begin
            r_rr_ptr  <= w_ptr_nxt;
            r_v_q     <= w_granted;
            r_id_q    <= w_win;
`ifdef ALU_ARB_LOCK_EN
            r_lock_q  <= w_lock_q_nxt;
            r_lock_id <= w_lock_id_nxt;
`endif
        end
    end

    assign o_rsp_valid  = r_v_q;
    assign o_rsp_id     = r_id_q;
    assign o_rsp_result = i_alu_result;
    assign o_rsp_cout   = i_alu_cout;
    assign o_rsp_zero   = i_alu_zero;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a registered ALU stand-in, directed scenarios and a randomized run
// checked against a queue-free behavioural model of round-robin arbitration (and lock, if enabled).
module tb_alu_arbiter;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned NUM_REQ   = 2;
    localparam int unsigned ID_BITS   = 1;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_BITS-1:0] op_a;
    logic [NUM_REQ*DATA_BITS-1:0] op_b;
    logic [NUM_REQ-1:0]           op_sub;
    logic [NUM_REQ-1:0]           lock;
    logic [NUM_REQ-1:0]           gnt;
    logic [DATA_BITS-1:0]         alu_a, alu_b, alu_result;
    logic                         alu_cin, alu_cout, alu_zero;
    logic                         rsp_valid;
    logic [ID_BITS-1:0]           rsp_id;
    logic [DATA_BITS-1:0]         rsp_result;
    logic                         rsp_cout, rsp_zero;

    int checks   = 0;
    int failures = 0;

    // Model state: pointer, lock, and the response expected in the coming cycle.
    int                   m_ptr;
    bit                   m_lock;
    int                   m_lock_id;
    bit                   m_v;
    int                   m_id;
    logic [DATA_BITS-1:0] m_res;
    bit                   m_cout, m_zero;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_BITS(DATA_BITS), .NUM_REQ(NUM_REQ), .ID_BITS(ID_BITS)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_req(req), .i_op_a(op_a), .i_op_b(op_b),
        .i_op_sub(op_sub),
`ifdef ALU_ARB_LOCK_EN
        .i_lock(lock),
`endif
        .o_gnt(gnt), .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cin(alu_cin),
        .i_alu_result(alu_result), .i_alu_cout(alu_cout), .i_alu_zero(alu_zero),
        .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
        .o_rsp_cout(rsp_cout), .o_rsp_zero(rsp_zero)
    );

    // Registered ALU: a + (cin ? ~b : b) + cin, synchronous active-high reset driven by ~rst_n.
    always @(posedge clk) begin
        logic [DATA_BITS:0] sum;
        sum = {1'b0, alu_a} + {1'b0, (alu_cin ? ~alu_b : alu_b)} + (DATA_BITS+1)'(alu_cin);
        if (!rst_n) begin
            alu_result <= '0;
            alu_cout   <= 1'b0;
            alu_zero   <= 1'b0;
        end else begin
            alu_result <= sum[DATA_BITS-1:0];
            alu_cout   <= sum[DATA_BITS];
            alu_zero   <= (sum[DATA_BITS-1:0] == '0);
        end
    end

    function automatic int model_win();
        if (m_lock) return req[m_lock_id] ? m_lock_id : -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NUM_REQ;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] model_gnt();
        int w;
        w = model_win();
        model_gnt = '0;
        if (w >= 0) model_gnt[w] = 1'b1;
    endfunction

    // Predict the effect of the coming posedge from the current inputs.
    task automatic model_commit();
        int w;
        int a, b;
        w = model_win();
        m_v = (w >= 0);
        if (w >= 0) begin
            a = int'(op_a[w*DATA_BITS +: DATA_BITS]);
            b = int'(op_b[w*DATA_BITS +: DATA_BITS]);
            if (op_sub[w]) begin
                m_res  = DATA_BITS'(a - b);
                m_cout = (a >= b);
            end else begin
                m_res  = DATA_BITS'(a + b);
                m_cout = (a + b) >= (1 << DATA_BITS);
            end
            m_zero = (m_res == 0);
            m_id   = w;
`ifdef ALU_ARB_LOCK_EN
            if (lock[w]) begin
                m_lock    = 1'b1;
                m_lock_id = w;
            end else begin
                m_lock = 1'b0;
                m_ptr  = (w + 1) % NUM_REQ;
            end
`else
            m_ptr = (w + 1) % NUM_REQ;
`endif
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_lock = 0; m_lock_id = 0; m_v = 0; m_id = 0;
    endtask

    task automatic set_op(input int i, input logic [DATA_BITS-1:0] a,
                          input logic [DATA_BITS-1:0] b, input logic sub);
        op_a[i*DATA_BITS +: DATA_BITS] = a;
        op_b[i*DATA_BITS +: DATA_BITS] = b;
        op_sub[i] = sub;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; op_a = '0; op_b = '0; op_sub = '0; lock = '0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 2'b01) begin failures++; $display("FAIL reset_gnt: got %b expected 01", gnt); end
            checks++;
            if (rsp_valid !== 1'b0 || rsp_id !== 1'b0) begin
                failures++; $display("FAIL reset_rsp: got valid=%b id=%0d expected 0/0", rsp_valid, rsp_id);
            end
            next_cycle();
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL reset_first_gnt: got gnt=%b valid=%b expected 01/0", gnt, rsp_valid);
        end
        model_commit();
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL reset_first_rsp: got valid=%b id=%0d expected 1/0", rsp_valid, rsp_id);
        end
        model_commit();
        next_cycle();
    endtask

    task automatic test_add_single();
        req = 2'b01; set_op(0, 8'h05, 8'h03, 1'b0);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL add_gnt: got %b expected 01", gnt); end
        model_commit();
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 8'h08 ||
            rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            failures++;
            $display("FAIL add_rsp: got v=%b id=%0d r=%h c=%b z=%b expected 1 0 08 0 0",
                     rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero);
        end
        model_commit();
        next_cycle();
    endtask

    task automatic test_sub_zero();
        req = 2'b10; set_op(1, 8'h07, 8'h07, 1'b1);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL sub_gnt: got %b expected 10", gnt); end
        model_commit();
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 8'h00 ||
            rsp_cout !== 1'b1 || rsp_zero !== 1'b1) begin
            failures++;
            $display("FAIL sub_rsp: got v=%b id=%0d r=%h c=%b z=%b expected 1 1 00 1 1",
                     rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero);
        end
        model_commit();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        set_op(0, 8'hFF, 8'h01, 1'b0);
        set_op(1, 8'h10, 8'h01, 1'b1);
        for (int c = 0; c < 7; c++) begin
            logic [NUM_REQ-1:0] eg;
            int p;
            req = (c < 6) ? 2'b11 : 2'b00;
            eg  = (c == 6) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
            @(negedge clk);
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", c, gnt, eg); end
            if (c > 0) begin
                p = (c - 1) % 2;
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== ID_BITS'(p) ||
                    rsp_result !== ((p == 0) ? 8'h00 : 8'h0F) ||
                    rsp_cout !== 1'b1 || rsp_zero !== (p == 0)) begin
                    failures++;
                    $display("FAIL b2b_rsp[%0d]: got v=%b id=%0d r=%h c=%b z=%b", c,
                             rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_zero);
                end
            end
            model_commit();
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        req = 2'b11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            model_commit();
            next_cycle();
        end
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid_low: got %b expected 0", rsp_valid); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid_after: got %b expected 0", rsp_valid); end
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL midrst_gnt: got %b expected 01", gnt); end
        model_commit();
        next_cycle();
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0) begin
            failures++; $display("FAIL midrst_rsp: got v=%b id=%0d expected 1/0", rsp_valid, rsp_id);
        end
        model_commit();
        next_cycle();
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        rst_n = 1'b0; req = '0; lock = '0;
        model_reset();
        next_cycle();
        rst_n = 1'b1;
        set_op(0, 8'h11, 8'h22, 1'b0);
        set_op(1, 8'h33, 8'h01, 1'b1);
        for (int c = 0; c < 5; c++) begin
            logic [NUM_REQ-1:0] eg;
            req  = 2'b11;
            lock = (c < 3) ? 2'b01 : 2'b00;
            eg   = (c < 4) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL lock_gnt[%0d]: got %b expected %b", c, gnt, eg); end
            model_commit();
            next_cycle();
        end
        lock = '0; req = '0;
        @(negedge clk);
        model_commit();
        next_cycle();
    endtask
`endif

    task automatic test_random();
        logic [NUM_REQ-1:0] eg;
        eg = '0;
        req = '0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!(req[i] && !eg[i])) begin
                    req[i] = 1'($urandom_range(0, 1));
                    set_op(i, DATA_BITS'($urandom), DATA_BITS'($urandom), 1'($urandom_range(0, 1)));
                end
`ifdef ALU_ARB_LOCK_EN
                lock[i] = ($urandom_range(0, 3) == 0);
`endif
            end
            @(negedge clk);
            eg = model_gnt();
            checks++;
            if (gnt !== eg) begin failures++; $display("FAIL rnd_gnt[%0d]: got %b expected %b", c, gnt, eg); end
            if (eg == '0) begin
                checks++;
                if (alu_a !== '0 || alu_b !== '0 || alu_cin !== 1'b0) begin
                    failures++; $display("FAIL rnd_idle_alu[%0d]: got a=%h b=%h cin=%b expected 0", c, alu_a, alu_b, alu_cin);
                end
            end
            checks++;
            if (rsp_valid !== m_v) begin
                failures++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, rsp_valid, m_v);
            end else if (m_v) begin
                checks++;
                if (rsp_id !== ID_BITS'(m_id) || rsp_result !== m_res ||
                    rsp_cout !== m_cout || rsp_zero !== m_zero) begin
                    failures++;
                    $display("FAIL rnd_rsp[%0d]: got id=%0d r=%h c=%b z=%b expected id=%0d r=%h c=%b z=%b", c,
                             rsp_id, rsp_result, rsp_cout, rsp_zero, m_id, m_res, m_cout, m_zero);
                end
            end
            model_commit();
            next_cycle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_single();
        test_sub_zero();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered ALU (1-cycle latency, `cin`=1 selects subtract) among NUM_REQ requesters using round-robin arbitration.
- Grants at most one operation per cycle and muxes the winner's operands onto the ALU inputs.
- Tags the in-flight operation and returns the ALU result with the requester ID one cycle later.
- Sits between the ALU and its users: execute stage, PC/address incrementer, and similar.

Parameters:
- DATA_BITS, 8, operand/result width; must match the ALU.
- NUM_REQ, 2, number of requesters; legal range 2..8.
- ID_BITS, $clog2(NUM_REQ), width of the response ID.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  NUM_REQ  per-requester operation request.
- op_a  in  NUM_REQ*DATA_BITS  packed operand A; requester i occupies slice [i*DATA_BITS +: DATA_BITS].
- op_b  in  NUM_REQ*DATA_BITS  packed operand B, same packing.
- op_sub  in  NUM_REQ  1 = a-b, 0 = a+b.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- alu_a  out  DATA_BITS  to ALU a.
- alu_b  out  DATA_BITS  to ALU b.
- alu_cin  out  1  to ALU cin.
- alu_result  in  DATA_BITS  from ALU result.
- alu_cout  in  1  from ALU cout.
- alu_zero  in  1  from ALU zero.
- rsp_valid  out  1  response valid.
- rsp_id  out  ID_BITS  index of the requester that owns the response.
- rsp_result  out  DATA_BITS  = alu_result.
- rsp_cout  out  1  = alu_cout.
- rsp_zero  out  1  = alu_zero.

Behaviour:
- State: rr_ptr (ID_BITS), v_q (1), id_q (ID_BITS).
- Reset values: rr_ptr=0, v_q=0, id_q=0. Therefore rsp_valid=0 and rsp_id=0 during and right after reset. gnt follows req and rr_ptr combinationally.
- Arbitration, cycle N: search req starting at index rr_ptr and wrapping modulo NUM_REQ. The first set bit i wins and gnt[i]=1. gnt is never multi-hot and is all-zero when req==0.
- ALU drive, cycle N: alu_a=op_a[i], alu_b=op_b[i], alu_cin=op_sub[i]. With no grant, alu_a=0, alu_b=0, alu_cin=0.
- Update at posedge ending cycle N: v_q <= |req; id_q <= i; rr_ptr <= (i+1) mod NUM_REQ if granted, otherwise unchanged.
- Response, cycle N+1: rsp_valid=v_q, rsp_id=id_q, rsp_result/cout/zero pass through from the ALU. Latency is exactly 1 cycle from grant.
- Throughput: one op per cycle, back-to-back. No backpressure; the consumer must accept every response.
- Handshake: an op is accepted only in a cycle with gnt[i]=1. The requester must hold operands stable while req=1 and gnt[i]=0. It may keep req high to issue consecutive ops, but rotation still applies.
- Fairness: with all requesters asserting continuously, each gets exactly 1 grant per NUM_REQ cycles.
- Single requester active: granted every cycle, and rr_ptr advances past it.
- Reset mid-operation: the in-flight tag is dropped (v_q=0). No response is produced for an op granted in the cycle reset asserts.
- The ALU reset is active-high synchronous; the integrating level drives it with ~reset.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- With the macro: adds input `lock` (NUM_REQ) and internal state lock_q (1) and lock_id (ID_BITS), both reset to 0.
  - A grant to i with lock[i]=1 sets lock_q=1 and lock_id=i.
  - While lock_q=1, only requester lock_id may be granted. Other requests wait with gnt=0 for them. rr_ptr is frozen.
  - A grant to lock_id with lock=0 clears lock_q and advances rr_ptr normally.
  - If lock_id drops req while locked, the ALU idles, the lock persists, and alu_cin=0.
  - Used for multi-byte sequences (e.g., 16-bit add in two ops).
- Without the macro: no `lock` port, pure round-robin.

Test Plan:
- Reset held low 3 cycles with req=2'b11 -> gnt follows req but rsp_valid stays 0 throughout. After release, first grant goes to index 0.
- req=01, op_a0=8'h05, op_b0=8'h03, op_sub0=0 -> gnt=01. Next cycle rsp_valid=1, rsp_id=0, rsp_result=8'h08, cout=0, zero=0.
- req=10, op_a1=8'h07, op_b1=8'h07, op_sub1=1 -> next cycle rsp_id=1, rsp_result=8'h00, zero=1, cout=1.
- req=11 held 6 cycles, op_a0=8'hFF/op_b0=8'h01 add, op_a1=8'h10/op_b1=8'h01 sub -> gnt alternates 01,10,01,10,... Responses alternate 8'h00 (cout=1, zero=1) and 8'h0F.
- req=11 with reset pulsed low for 1 cycle mid-stream -> no response in the cycle after reset. rr_ptr is back at 0, so the next grant is 01.
- (ALU_ARB_LOCK_EN) req=11, lock0=1 for 3 ops then 0 -> gnt=01 for 4 consecutive cycles, then 10.
